uart_tx_word_sched: RTL and testbench

Transmit scheduler that shares one byte-wide UART transmitter between two 32-bit word requesters. The two requesters are the MIPS output register path and a debug/echo path. It arbitrates round-robin and latches the granted word. It serializes the word MSB-byte-first into the UART TX handshake (data-valid strobe, active, done). It sits between the datapath output registers and the UART TX block.

---
 rtl/uart_tx_word_sched.sv | 106 ++++++++++
 tb/tb_uart_tx_word_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_sched.sv
// Round-robin scheduler that shares one byte-wide UART transmitter between
// two word requesters. It sends the granted word MSB byte first.
module uart_tx_word_sched #(
    parameter int BIT_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [BIT_WIDTH-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [BIT_WIDTH-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 timeout_err
);

    localparam int NUM_BYTES = BIT_WIDTH / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMR_W     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]           state;
    logic                 last_grant;
    logic [BIT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     byte_cnt;
    logic [TMR_W-1:0]     timer;
    logic                 sel0;
    logic                 sel1;

    // Requester selection: a lone valid wins; on a tie the one not served last wins
    always_comb begin
        sel0       = req0_valid && (!req1_valid || last_grant);
        sel1       = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && sel0;
        req1_ready = (state == IDLE) && sel1;
        busy       = (state != IDLE);
    end

    // Word scheduler: accept, strobe each byte, wait for completion or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            shreg       <= '0;
            byte_cnt    <= '0;
            timer       <= '0;
            tx_dv       <= 1'b0;
            tx_byte     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel0 || sel1) begin
                        shreg      <= sel1 ? req1_data : req0_data;
                        grant_id   <= sel1;
                        last_grant <= sel1;
                        byte_cnt   <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= shreg[BIT_WIDTH-1 -: 8];
                        timer   <= '0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // tx_done has priority over a timeout in the same cycle
                    if (tx_done) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state <= IDLE;
                        end else begin
                            shreg    <= shreg << 8;
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= SEND;
                        end
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word_sched.sv
// Self-checking bench for uart_tx_word_sched with a byte-stream reference model.
module tb_uart_tx_word_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        tx_busy, tx_done, model_done, stray_done;
    logic        tx_dv, busy, grant_id, timeout_err;
    logic [7:0]  tx_byte;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         dv_count = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         dv_cyc_q[$];
    bit         acc_id_q[$];
    int         acc_cyc_q[$];
    int         last_done_cyc = -1;
    int         idle_cyc = -1;
    logic       prev_busy = 1'b0;

    bit auto_done  = 1'b1;
    int done_delay = 10;
    int pend       = 0;
    bit m_last     = 1'b1;

    assign tx_done = model_done | stray_done;

    uart_tx_word_sched #(.BIT_WIDTH(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // UART model: pulses tx_done done_delay cycles after each strobe
    initial begin
        model_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            model_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) model_done = 1'b1;
                end
                if (tx_dv && auto_done) pend = done_delay;
            end
        end
    end

    // Monitor: records strobed bytes, accepts and timing events
    initial forever begin
        @(negedge clk);
        if (tx_dv) begin
            got_q.push_back(tx_byte);
            dv_cyc_q.push_back(cyc);
            dv_count++;
        end
        if (tx_done) last_done_cyc = cyc;
        if (prev_busy && !busy) idle_cyc = cyc;
        prev_busy = busy;
        if (req0_valid && req0_ready) begin
            acc_id_q.push_back(1'b0);
            acc_cyc_q.push_back(cyc);
            chk("busy_at_accept0", 32'(busy), 32'd0);
        end
        if (req1_valid && req1_ready) begin
            acc_id_q.push_back(1'b1);
            acc_cyc_q.push_back(cyc);
            chk("busy_at_accept1", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(w >> (8 * i)));
    endfunction

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_accept(input int n, input string tag);
        int k = 0;
        while (acc_id_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_accept_seen"}, 32'(acc_id_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_words(input bit v0, input bit v1, input logic [31:0] d0,
                            input logic [31:0] d1, input string tag);
        int base;
        int n;
        bit first_id;
        base     = acc_id_q.size();
        n        = int'(v0) + int'(v1);
        first_id = (v0 && v1) ? !m_last : v1;
        req0_data  = d0;
        req1_data  = d1;
        req0_valid = v0;
        req1_valid = v1;
        for (int k = 0; k < n; k++) begin
            bit id;
            id = (k == 0) ? first_id : !first_id;
            wait_accept(base + k + 1, tag);
            chk({tag, "_order"}, 32'(acc_id_q[base + k]), 32'(id));
            chk({tag, "_grant_id"}, 32'(grant_id), 32'(id));
            push_word(id ? d1 : d0);
            if (id) req1_valid = 1'b0;
            else    req0_valid = 1'b0;
            m_last = id;
        end
        wait_idle(tag);
        tick();
        check_bytes(tag);
    endtask

    initial begin
        int n0, a_cyc, drop_cyc, to_cyc, k, base, sel;
        bit exp_id;
        logic [31:0] w;

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; tx_busy = 1'b0; stray_done = 1'b0;
        repeat (3) tick();
        chk("rst_tx_dv", 32'(tx_dv), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        rst = 1'b0;
        tick();

        // single word with fixed UART delay
        done_delay = 10;
        n0 = dv_count;
        base = acc_id_q.size();
        req0_data = 32'hA1B2C3D4;
        req0_valid = 1'b1;
        push_word(32'hA1B2C3D4);
        wait_accept(base + 1, "single");
        a_cyc = acc_cyc_q[base];
        req0_valid = 1'b0;
        m_last = 1'b0;
        chk("single_grant_id", 32'(grant_id), 32'd0);
        wait_idle("single");
        tick();
        check_bytes("single");
        chk("single_dv_count", 32'(dv_count - n0), 32'd4);
        chk("single_first_dv_latency", 32'(dv_cyc_q[n0] - a_cyc), 32'd2);
        chk("single_idle_after_done", 32'(idle_cyc - last_done_cyc), 32'd1);

        // randomized single and contended words
        repeat (6) begin
            sel = $urandom_range(0, 2);
            done_delay = $urandom_range(1, 12);
            do_words(sel != 1, sel != 0, $urandom, $urandom, "rand");
        end

        // fairness with both requesters held valid
        do_reset();
        done_delay = 3;
        base = acc_id_q.size();
        req0_data = 32'h11111111;
        req1_data = 32'h22222222;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = !m_last;
            wait_accept(base + i + 1, "arb");
            chk("arb_order", 32'(acc_id_q[base + i]), 32'(exp_id));
            chk("arb_grant_id", 32'(grant_id), 32'(exp_id));
            push_word(exp_id ? 32'h22222222 : 32'h11111111);
            m_last = exp_id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("arb");
        tick();
        check_bytes("arb");

        // UART busy stall after accept
        tx_busy = 1'b1;
        w = $urandom;
        base = acc_id_q.size();
        req0_data = w;
        req0_valid = 1'b1;
        wait_accept(base + 1, "stall");
        req0_valid = 1'b0;
        m_last = 1'b0;
        push_word(w);
        n0 = dv_count;
        repeat (20) tick();
        chk("stall_no_dv", 32'(dv_count), 32'(n0));
        tx_busy = 1'b0;
        drop_cyc = cyc;
        tick();
        tick();
        chk("stall_one_dv", 32'(dv_count), 32'(n0 + 1));
        chk("stall_dv_cycle", 32'(dv_cyc_q[n0]), 32'(drop_cyc + 1));
        wait_idle("stall");
        tick();
        check_bytes("stall");

        // timeout with no tx_done
        auto_done = 1'b0;
        w = $urandom;
        n0 = dv_count;
        base = acc_id_q.size();
        req1_data = w;
        req1_valid = 1'b1;
        wait_accept(base + 1, "tmo");
        req1_valid = 1'b0;
        m_last = 1'b1;
        k = 0;
        while (!timeout_err && k < 60) begin
            tick();
            k++;
        end
        to_cyc = cyc;
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_delay", 32'(to_cyc - dv_cyc_q[n0]), 32'd16);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick();
        chk("tmo_dv_count", 32'(dv_count - n0), 32'd1);
        exp_q.push_back(w[31:24]);
        check_bytes("tmo");
        auto_done = 1'b1;
        done_delay = 5;
        do_words(1'b1, 1'b0, $urandom, 32'h0, "post_tmo");
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // reset in the middle of a word
        done_delay = 10;
        n0 = dv_count;
        base = acc_id_q.size();
        req0_data = 32'hDEADBEEF;
        req0_valid = 1'b1;
        wait_accept(base + 1, "midrst");
        req0_valid = 1'b0;
        k = 0;
        while (dv_count < n0 + 2 && k < 100) begin
            tick();
            k++;
        end
        rst = 1'b1;
        tick();
        chk("midrst_tx_dv", 32'(tx_dv), 32'd0);
        chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        m_last = 1'b1;
        repeat (30) tick();
        chk("midrst_no_more_dv", 32'(dv_count), 32'(n0 + 2));
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        check_bytes("midrst");
        do_words(1'b0, 1'b1, 32'h0, $urandom, "after_rst");

        // stray tx_done in IDLE and in SEND
        n0 = dv_count;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_dv", 32'(dv_count), 32'(n0));
        tx_busy = 1'b1;
        w = $urandom;
        base = acc_id_q.size();
        req0_data = w;
        req0_valid = 1'b1;
        wait_accept(base + 1, "stray");
        req0_valid = 1'b0;
        m_last = 1'b0;
        push_word(w);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        chk("stray_send_busy", 32'(busy), 32'd1);
        chk("stray_send_dv", 32'(dv_count), 32'(n0));
        tx_busy = 1'b0;
        wait_idle("stray");
        tick();
        check_bytes("stray");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
